// File: rtl/display_mode_arbiter_pkg.sv
// Shared definitions for the display/button ownership arbiter.
package display_mode_arbiter_pkg;

  localparam logic [1:0] SRC_CLOCK  = 2'd0;
  localparam logic [1:0] SRC_ALARM  = 2'd1;
  localparam logic [1:0] SRC_TIMER  = 2'd2;
  localparam logic [1:0] SRC_SWATCH = 2'd3;

  localparam logic [7:0] BLANK_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_BLANK,
    ST_OVR,
    ST_OVR_BLANK
  } arb_state_e;

  // Next enabled source after cur, wrapping mod 4; returns cur if no other is enabled.
  function automatic logic [1:0] next_owner(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] cand;
    logic       found;
    next_owner = cur;
    found      = 1'b0;
    for (int unsigned i = 1; i < 4; i++) begin
      cand = cur + 2'(i);
      if (!found && en[cand]) begin
        next_owner = cand;
        found      = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/display_mode_arbiter_idle_timer.sv
// Saturating idle counter: expires at TIMEOUT_CYC-1 unless held by a busy owner.
module arb_idle_timer #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd3_000_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic hold,
  output logic expired
);

  logic [31:0] cnt_q, cnt_d;
  logic        at_limit;

  // Count while enabled, clear on activity, saturate at the limit.
  always_comb begin
    at_limit = (cnt_q == TIMEOUT_CYC - 32'd1);
    cnt_d    = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && !at_limit)
      cnt_d = cnt_q + 32'd1;
    expired = enable && at_limit && !hold;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_mode_arbiter.sv
// Arbitrates the shared display and buttons among clock/alarm/timer/stopwatch.
module display_mode_arbiter
  import display_mode_arbiter_pkg::*;
#(
  parameter logic [3:0]  SRC_EN      = 4'b1111,
  parameter logic [31:0] TIMEOUT_CYC = 32'd3_000_000_000,
  parameter logic [31:0] BLANK_CYC   = 32'd5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_btn,
  input  logic        ent_in,
  input  logic        ret_in,
  input  logic        bstep_in,
  input  logic [3:0]  busy,
  input  logic        alarm_ring,
  input  logic [31:0] seg_in,
  input  logic [31:0] dig_in,
  output logic [3:0]  ent_out,
  output logic [3:0]  ret_out,
  output logic [3:0]  bstep_out,
  output logic [7:0]  segm,
  output logic [7:0]  dign,
  output logic [1:0]  owner,
  output logic        override
);

  arb_state_e  state_q, state_d;
  logic [1:0]  owner_q, owner_d, saved_q, saved_d;
  logic        override_q, override_d;
  logic [31:0] blank_cnt_q, blank_cnt_d;
  logic        mode_prev_q, mode_prev_d;
  logic [2:0]  btn_prev_q, btn_prev_d, rel_q, rel_d;
  logic [7:0]  segm_q, segm_d, dign_q, dign_d;

  logic [2:0]  btn_in, btn_pass;
  logic [1:0]  nxt;
  logic        mode_rise, btn_rise_any, owner_chg;
  logic        in_ovr, in_blank, blank_done;
  logic        tmr_clear, tmr_enable, tmr_expired;

  // Edge detection and state decode.
  always_comb begin
    btn_in       = {bstep_in, ret_in, ent_in};
    mode_prev_d  = mode_btn;
    btn_prev_d   = btn_in;
    mode_rise    = mode_btn && !mode_prev_q;
    btn_rise_any = |(btn_in & ~btn_prev_q);
    in_ovr       = (state_q == ST_OVR) || (state_q == ST_OVR_BLANK);
    in_blank     = (state_q == ST_BLANK) || (state_q == ST_OVR_BLANK);
    blank_done   = (blank_cnt_q == BLANK_CYC - 32'd1);
    nxt          = next_owner(owner_q, SRC_EN);
  end

  // Next-state / ownership logic: alarm > mode edge > idle timeout.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    saved_d     = saved_q;
    override_d  = override_q;
    blank_cnt_d = '0;
    if (!in_ovr && alarm_ring) begin
      saved_d    = owner_q;
      owner_d    = SRC_ALARM;
      override_d = 1'b1;
      state_d    = ST_OVR_BLANK;
    end else if (in_ovr && !alarm_ring) begin
      owner_d    = saved_q;
      override_d = 1'b0;
      state_d    = ST_BLANK;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (mode_rise) begin
            if (!busy[owner_q] && (nxt != owner_q)) begin
              owner_d = nxt;
              state_d = ST_BLANK;
            end
          end else if (tmr_expired && !btn_rise_any) begin
            owner_d = SRC_CLOCK;
            state_d = ST_BLANK;
          end
        end
        ST_BLANK, ST_OVR_BLANK: begin
          if (blank_done)
            state_d = (state_q == ST_BLANK) ? ST_NORMAL : ST_OVR;
          else
            blank_cnt_d = blank_cnt_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Button routing with per-button release tracking across ownership changes.
  always_comb begin
    owner_chg = (owner_d != owner_q);
    rel_d     = btn_in & (rel_q | {3{owner_chg}});
    btn_pass  = btn_in & ~rel_q & {3{!(owner_chg || in_blank || rst)}};
    ent_out   = btn_pass[0] ? (4'b0001 << owner_q) : '0;
    ret_out   = btn_pass[1] ? (4'b0001 << owner_q) : '0;
    bstep_out = btn_pass[2] ? (4'b0001 << owner_q) : '0;
  end

  // Display mux: owner's bytes, or blank while a blank state is active.
  always_comb begin
    if (in_blank) begin
      segm_d = BLANK_BYTE;
      dign_d = BLANK_BYTE;
    end else begin
      segm_d = seg_in[{owner_q, 3'b000} +: 8];
      dign_d = dig_in[{owner_q, 3'b000} +: 8];
    end
  end

  // Idle timer control.
  always_comb begin
    tmr_clear  = mode_rise || btn_rise_any || owner_chg;
    tmr_enable = (state_q == ST_NORMAL) && (owner_q != SRC_CLOCK);
  end

  arb_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .hold    (busy[owner_q]),
    .expired (tmr_expired)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_NORMAL;
      owner_q     <= SRC_CLOCK;
      saved_q     <= SRC_CLOCK;
      override_q  <= 1'b0;
      blank_cnt_q <= '0;
      mode_prev_q <= 1'b0;
      btn_prev_q  <= '0;
      rel_q       <= '0;
      segm_q      <= BLANK_BYTE;
      dign_q      <= BLANK_BYTE;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      saved_q     <= saved_d;
      override_q  <= override_d;
      blank_cnt_q <= blank_cnt_d;
      mode_prev_q <= mode_prev_d;
      btn_prev_q  <= btn_prev_d;
      rel_q       <= rel_d;
      segm_q      <= segm_d;
      dign_q      <= dign_d;
    end
  end

  assign owner    = owner_q;
  assign override = override_q;
  assign segm     = segm_q;
  assign dign     = dign_q;

endmodule
